// File: rtl/afpm_pkg.sv
// Shared definitions for the approximate FP multiplier sequencer.
// Holds the sequencer state encoding, bus widths, the default
// watchdog limit and the operand type.
package afpm_pkg;

    localparam int BYTE_W          = 8;
    localparam int OP_W            = 2 * BYTE_W;
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

    typedef logic [OP_W-1:0] op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        SEND_LO = 3'd4,
        SEND_HI = 3'd5
    } state_t;

endpackage

// File: rtl/afpm_watchdog.sv
// Watchdog down-counter for the multiplier wait phase.
// Ports:
//   clk, rst   - clock, async active-high reset (count -> 0)
//   clr_i      - synchronous clear to 0 (highest priority after rst)
//   load_i     - load TIMEOUT-1
//   en_i       - decrement by one, saturating at 0
//   expire_o   - count has reached 0
// After a load, expire_o rises on the TIMEOUT-th enabled cycle, which
// is the cycle in which the owner must give up waiting.
module afpm_watchdog
    import afpm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(TIMEOUT - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/afpm_seq_ctrl.sv
// Sequencer in front of the 16-bit logarithmic approximate FP multiplier.
// Assembles byte-serial operands (low byte first), issues a one-cycle
// start to the core, waits for done under a watchdog, then streams the
// product back as two bytes (low, then high with out_last).
// Ports:
//   clk, rst                 - clock, async active-high reset
//   flush                    - synchronous abort of the current job
//   in_valid/in_ready        - operand byte pair handshake (in_a_byte, in_b_byte)
//   mul_start, mul_a, mul_b  - request to the core
//   mul_done, mul_result     - response from the core
//   out_valid/out_ready      - result byte handshake (out_byte, out_last)
//   busy                     - job in progress (state != IDLE)
//   timeout_err              - sticky watchdog flag, cleared by next job start
//   dbg_state                - current sequencer state
// Handshake: a byte moves on a rising edge where valid and ready are both 1;
// valid and payload hold until that edge. All outputs decode registered state.
module afpm_seq_ctrl
    import afpm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_a_byte,
    input  logic [BYTE_W-1:0] in_b_byte,
    output logic              in_ready,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [OP_W-1:0]   mul_result,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              timeout_err,
    output state_t            dbg_state
);

    state_t state_q, state_d;
    op_t    a_q, b_q, res_q;
    logic   err_q;

    logic wd_load, wd_en, wd_expire;

    afpm_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        wd_load = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD_HI;
            LOAD_HI: if (in_valid) state_d = ISSUE;
            ISSUE: begin
                // mul_done here is ignored; the core has not seen start yet
                wd_load = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over a simultaneous expiry
                if (mul_done) begin
                    state_d = SEND_LO;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end else begin
                    wd_en = 1'b1;
                end
            end
            SEND_LO: if (out_ready) state_d = SEND_HI;
            SEND_HI: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!flush) begin
                case (state_q)
                    IDLE: if (in_valid) begin
                        // high byte cleared so no stale half survives
                        a_q   <= {{BYTE_W{1'b0}}, in_a_byte};
                        b_q   <= {{BYTE_W{1'b0}}, in_b_byte};
                        err_q <= 1'b0;
                    end
                    LOAD_HI: if (in_valid) begin
                        a_q[OP_W-1:BYTE_W] <= in_a_byte;
                        b_q[OP_W-1:BYTE_W] <= in_b_byte;
                    end
                    WAIT: begin
                        if (mul_done) begin
                            res_q <= mul_result;
                        end else if (wd_expire) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        out_byte = '0;
        case (state_q)
            SEND_LO: out_byte = res_q[BYTE_W-1:0];
            SEND_HI: out_byte = res_q[OP_W-1:BYTE_W];
            default: out_byte = '0;
        endcase
    end

    assign in_ready    = (state_q == IDLE) || (state_q == LOAD_HI);
    assign mul_start   = (state_q == ISSUE);
    assign out_valid   = (state_q == SEND_LO) || (state_q == SEND_HI);
    assign out_last    = (state_q == SEND_HI);
    assign busy        = (state_q != IDLE);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Self-checking bench for afpm_seq_ctrl.
module tb_afpm_seq_ctrl;
    import afpm_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a_byte = '0;
    logic [7:0]  in_b_byte = '0;
    logic        in_ready;
    logic        mul_start;
    logic [15:0] mul_a, mul_b;
    logic        mul_done = 1'b0;
    logic [15:0] mul_result = '0;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        timeout_err;
    state_t      dbg_state;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [8:0] exp_q[$];

    afpm_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_a_byte(in_a_byte), .in_b_byte(in_b_byte),
        .in_ready(in_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // scoreboard: every accepted output byte is compared with the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", {23'd0, out_last, out_byte}, 32'h1ff);
            end else begin
                check_eq("out_byte_last", {23'd0, out_last, out_byte}, {23'd0, exp_q.pop_front()});
            end
        end
        if (!rst && mul_start) start_cnt++;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_a_byte = a;
        in_b_byte = b;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check_eq("in_ready_wait", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    // done_cyc: WAIT cycle in which the core answers (0 = never)
    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                           input int done_cyc, input int stall, input bit glitch);
        int base;
        int n;
        int lim;
        base = start_cnt;
        out_ready = (stall == 0);
        send_pair(a[7:0], b[7:0]);
        send_pair(a[15:8], b[15:8]);
        check_eq("issue_state", dbg_state, ISSUE);
        check_eq("mul_start", mul_start, 1'b1);
        check_eq("mul_a", mul_a, a);
        check_eq("mul_b", mul_b, b);
        check_eq("in_ready_issue", in_ready, 1'b0);
        if (done_cyc > 0) begin
            exp_q.push_back({1'b0, res[7:0]});
            exp_q.push_back({1'b1, res[15:8]});
        end
        mul_done   = glitch;
        mul_result = 16'hDEAD;
        lim = (done_cyc > 0) ? done_cyc : TO;
        for (int k = 1; k <= lim; k++) begin
            step();
            check_eq("wait_state", dbg_state, WAIT);
            check_eq("wait_no_err", timeout_err, 1'b0);
            mul_done   = (k == done_cyc);
            mul_result = (k == done_cyc) ? res : 16'($urandom);
        end
        step();
        mul_done = 1'b0;
        check_eq("start_pulses", start_cnt, base + 1);
        if (done_cyc == 0) begin
            check_eq("timeout_err", timeout_err, 1'b1);
            check_eq("timeout_idle", dbg_state, IDLE);
            check_eq("timeout_in_ready", in_ready, 1'b1);
        end else begin
            check_eq("send_lo_state", dbg_state, SEND_LO);
            check_eq("send_lo_valid", out_valid, 1'b1);
            check_eq("send_lo_byte", out_byte, res[7:0]);
            check_eq("no_err_after_done", timeout_err, 1'b0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check_eq("stall_valid", out_valid, 1'b1);
                check_eq("stall_byte", out_byte, res[7:0]);
                check_eq("stall_state", dbg_state, SEND_LO);
                step();
            end
            out_ready = 1'b1;
            n = 0;
            while (busy && n < 20) begin
                step();
                n++;
            end
            check_eq("job_done_busy", busy, 1'b0);
        end
        check_eq("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", dbg_state, IDLE);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_out_byte", out_byte, 8'h00);
        check_eq("rst_mul_start", mul_start, 1'b0);
        check_eq("rst_mul_a", mul_a, 16'h0000);
        check_eq("rst_mul_b", mul_b, 16'h0000);
        check_eq("rst_err", timeout_err, 1'b0);
        #1 rst = 1'b0;
        step();

        // basic job, with a spurious done during ISSUE
        run_job(16'h44DF, 16'h483D, 16'h5123, 2, 0, 1'b1);
        // output backpressure
        run_job(16'h44DF, 16'h483D, 16'h5123, 2, 5, 1'b0);
        // timeout
        run_job(16'h1111, 16'h2222, 16'h0000, 0, 0, 1'b0);
        // flush must not touch the sticky flag
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_keeps_err", timeout_err, 1'b1);
        // next accepted pair clears the flag
        send_pair(8'h01, 8'h02);
        check_eq("err_cleared", timeout_err, 1'b0);
        check_eq("load_hi_state", dbg_state, LOAD_HI);
        // flush mid-assembly discards the partial operand
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_load_idle", dbg_state, IDLE);
        // done on the expiry cycle wins
        run_job(16'h3C00, 16'h4000, 16'h4E00, TO, 0, 1'b0);

        // flush during WAIT
        send_pair(8'h55, 8'h66);
        send_pair(8'h77, 8'h88);
        step();
        step();
        check_eq("pre_flush_wait", dbg_state, WAIT);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_idle", dbg_state, IDLE);
        check_eq("flush_in_ready", in_ready, 1'b1);
        check_eq("flush_busy", busy, 1'b0);
        repeat (3) step();

        // randomised jobs
        for (int j = 0; j < 6; j++) begin
            run_job(16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(1, TO), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // async reset during SEND_HI
        out_ready = 1'b0;
        send_pair(8'h34, 8'h78);
        send_pair(8'h12, 8'h56);
        exp_q.push_back({1'b0, 8'hEF});
        exp_q.push_back({1'b1, 8'hBE});
        step();
        mul_done   = 1'b1;
        mul_result = 16'hBEEF;
        step();
        mul_done  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("send_hi_state", dbg_state, SEND_HI);
        check_eq("send_hi_last", out_last, 1'b1);
        check_eq("send_hi_byte", out_byte, 8'hBE);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_state", dbg_state, IDLE);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_mul_a", mul_a, 16'h0000);
        check_eq("arst_in_ready", in_ready, 1'b1);
        check_eq("arst_pending", exp_q.size(), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        run_job(16'h0101, 16'h0101, 16'h0A0B, 2, 0, 1'b0);

        repeat (3) step();
        check_eq("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
